fetch_ctrl: RTL and testbench

- Program-counter and fetch-control stage that drives the address input of the instruction ROM (9-bit machine code, 2**D words deep).
- Holds the PC and sequences start, run and halt.
- Resolves taken branches: absolute targets come from an internal writable branch-target LUT; relative targets are computed as PC plus a signed offset.
- Counts executed cycles for performance reporting.

---
 rtl/fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_fetch_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Program counter / fetch sequencer: IDLE -> RUN -> DONE, LUT-based absolute and PC-relative branches, saturating RUN cycle counter.
// All outputs come straight from flops; ROM lookup latency is added downstream.
module fetch_ctrl #(
    parameter int D  = 10,
    parameter int LW = 5,
    parameter int OW = 8,
    parameter int CW = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stall,
    input  logic          Branch_en,
    input  logic          Branch_rel,
    input  logic [LW-1:0] Target_idx,
    input  logic [OW-1:0] Rel_offset,
    input  logic          Halt_req,
    input  logic          Lut_we,
    input  logic [LW-1:0] Lut_addr,
    input  logic [D-1:0]  Lut_data,
    output logic [D-1:0]  prog_ctr,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] Cycle_cnt
);

    localparam int EXT = D - OW;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          running_q, running_d;
    logic          done_q, done_d;
    logic [D-1:0]  lut_q [2**LW];

    logic [D-1:0]  rel_ext;
    logic [D-1:0]  abs_tgt;

    assign rel_ext = {{EXT{Rel_offset[OW-1]}}, Rel_offset};
    // Read of the registered array: a same-cycle write is seen only next cycle.
    assign abs_tgt = lut_q[Target_idx];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                pc_d  = '0;
                if (Start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (Halt_req) begin
                    state_d = DONE;
                end else if (Stall) begin
                    pc_d = pc_q;
                end else if (Branch_en && !Branch_rel) begin
                    pc_d = abs_tgt;
                end else if (Branch_en) begin
                    pc_d = pc_q + rel_ext;
                end else begin
                    pc_d = pc_q + D'(1);
                end
            end
            DONE: begin
                if (Start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
                cnt_d   = '0;
            end
        endcase
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < 2**LW; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            running_q <= running_d;
            done_q    <= done_d;
            if (Lut_we) begin
                lut_q[Lut_addr] <= Lut_data;
            end
        end
    end

    assign prog_ctr  = pc_q;
    assign Running   = running_q;
    assign Done      = done_q;
    assign Cycle_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, sequencing, LUT/relative branches, stall, halt, restart, counter saturation.
module tb_fetch_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        Stall = 1'b0;
    logic        Branch_en = 1'b0;
    logic        Branch_rel = 1'b0;
    logic [4:0]  Target_idx = '0;
    logic [7:0]  Rel_offset = '0;
    logic        Halt_req = 1'b0;
    logic        Lut_we = 1'b0;
    logic [4:0]  Lut_addr = '0;
    logic [9:0]  Lut_data = '0;
    logic [9:0]  prog_ctr;
    logic        Running;
    logic        Done;
    logic [15:0] Cycle_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    logic [15:0] cnt_snap;

    fetch_ctrl #(.D(10), .LW(5), .OW(8), .CW(16)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Stall      (Stall),
        .Branch_en  (Branch_en),
        .Branch_rel (Branch_rel),
        .Target_idx (Target_idx),
        .Rel_offset (Rel_offset),
        .Halt_req   (Halt_req),
        .Lut_we     (Lut_we),
        .Lut_addr   (Lut_addr),
        .Lut_data   (Lut_data),
        .prog_ctr   (prog_ctr),
        .Running    (Running),
        .Done       (Done),
        .Cycle_cnt  (Cycle_cnt)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        step(); step();
        Reset = 1'b0;
        chk("rst_pc", 32'(prog_ctr), 32'h0);
        chk("rst_running", 32'(Running), 32'h0);
        chk("rst_done", 32'(Done), 32'h0);
        chk("rst_cnt", 32'(Cycle_cnt), 32'h0);

        // Run-only controls ignored while idle
        Halt_req = 1'b1; Branch_en = 1'b1; Stall = 1'b1;
        step();
        Halt_req = 1'b0; Branch_en = 1'b0; Stall = 1'b0;
        chk("idle_pc", 32'(prog_ctr), 32'h0);
        chk("idle_running", 32'(Running), 32'h0);
        chk("idle_done", 32'(Done), 32'h0);

        // Start and free-run
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("start_running", 32'(Running), 32'h1);
        chk("start_pc", 32'(prog_ctr), 32'h0);
        chk("start_cnt", 32'(Cycle_cnt), 32'h0);
        step(); chk("seq_pc1", 32'(prog_ctr), 32'h1);
        step(); chk("seq_pc2", 32'(prog_ctr), 32'h2);
        Lut_we = 1'b1; Lut_addr = 5'd5; Lut_data = 10'h077;
        step();
        Lut_we = 1'b0;
        chk("seq_pc3", 32'(prog_ctr), 32'h3);
        chk("seq_cnt3", 32'(Cycle_cnt), 32'h3);
        repeat (4) step();
        chk("seq_pc7", 32'(prog_ctr), 32'h7);

        // Mid-run reset clears state and LUT
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("mid_rst_pc", 32'(prog_ctr), 32'h0);
        chk("mid_rst_running", 32'(Running), 32'h0);
        chk("mid_rst_cnt", 32'(Cycle_cnt), 32'h0);

        // Absolute branches through the LUT
        Lut_we = 1'b1; Lut_addr = 5'd3; Lut_data = 10'h155;
        step();
        Lut_we = 1'b0;
        Start = 1'b1;
        step();
        Start = 1'b0;
        repeat (4) step();
        chk("abs_pre_pc", 32'(prog_ctr), 32'h4);
        Branch_en = 1'b1; Branch_rel = 1'b0; Target_idx = 5'd3;
        step();
        chk("abs_pc", 32'(prog_ctr), 32'h155);
        Lut_we = 1'b1; Lut_addr = 5'd3; Lut_data = 10'h020;
        step();
        Lut_we = 1'b0;
        chk("abs_old_entry", 32'(prog_ctr), 32'h155);
        step();
        chk("abs_new_entry", 32'(prog_ctr), 32'h020);
        Target_idx = 5'd5;
        step();
        Branch_en = 1'b0;
        chk("abs_lut_cleared", 32'(prog_ctr), 32'h0);

        // Relative branches with wrap
        repeat (5) step();
        chk("rel_pre_pc", 32'(prog_ctr), 32'h5);
        Branch_en = 1'b1; Branch_rel = 1'b1; Rel_offset = 8'hF8;
        step();
        Branch_en = 1'b0;
        chk("rel_neg", 32'(prog_ctr), 32'h3FD);
        step();
        chk("rel_pre2_pc", 32'(prog_ctr), 32'h3FE);
        Branch_en = 1'b1; Rel_offset = 8'h03;
        step();
        Branch_en = 1'b0; Branch_rel = 1'b0;
        chk("rel_pos_wrap", 32'(prog_ctr), 32'h001);
        Lut_we = 1'b1; Lut_addr = 5'd7; Lut_data = 10'h3FF;
        step();
        Lut_we = 1'b0;
        chk("lut_wr_run_pc", 32'(prog_ctr), 32'h002);
        Branch_en = 1'b1; Target_idx = 5'd7;
        step();
        Branch_en = 1'b0;
        chk("abs_to_top", 32'(prog_ctr), 32'h3FF);
        step();
        chk("inc_wrap", 32'(prog_ctr), 32'h000);

        // Stall, stall+branch, halt+branch
        repeat (9) step();
        chk("stall_pre_pc", 32'(prog_ctr), 32'h9);
        cnt_snap = Cycle_cnt;
        Stall = 1'b1;
        repeat (3) step();
        chk("stall_pc", 32'(prog_ctr), 32'h9);
        chk("stall_cnt", 32'(Cycle_cnt), 32'(cnt_snap + 16'd3));
        Branch_en = 1'b1; Target_idx = 5'd3;
        step();
        Stall = 1'b0; Branch_en = 1'b0;
        chk("stall_branch_pc", 32'(prog_ctr), 32'h9);
        step();
        chk("post_stall_pc", 32'(prog_ctr), 32'hA);
        Halt_req = 1'b1; Branch_en = 1'b1;
        step();
        Halt_req = 1'b0; Branch_en = 1'b0;
        chk("halt_branch_pc", 32'(prog_ctr), 32'hA);
        chk("halt_branch_done", 32'(Done), 32'h1);
        cnt_snap = Cycle_cnt;
        Stall = 1'b1; Branch_en = 1'b1;
        repeat (2) step();
        Stall = 1'b0; Branch_en = 1'b0;
        chk("done_hold_pc", 32'(prog_ctr), 32'hA);
        chk("done_hold_cnt", 32'(Cycle_cnt), 32'(cnt_snap));

        // Restart from DONE, then halt at 12
        Start = 1'b1;
        step();
        Start = 1'b0;
        chk("restart_running", 32'(Running), 32'h1);
        chk("restart_pc", 32'(prog_ctr), 32'h0);
        chk("restart_cnt", 32'(Cycle_cnt), 32'h0);
        repeat (12) step();
        chk("pre_halt_pc", 32'(prog_ctr), 32'hC);
        Halt_req = 1'b1;
        step();
        Halt_req = 1'b0;
        chk("halt_done", 32'(Done), 32'h1);
        chk("halt_running", 32'(Running), 32'h0);
        chk("halt_pc", 32'(prog_ctr), 32'hC);
        chk("halt_cnt", 32'(Cycle_cnt), 32'hD);
        step();
        chk("halt_hold_cnt", 32'(Cycle_cnt), 32'hD);
        chk("halt_hold_pc", 32'(prog_ctr), 32'hC);

        // Start ignored in RUN; counter saturation
        Start = 1'b1;
        step();
        chk("restart2_pc", 32'(prog_ctr), 32'h0);
        step();
        Start = 1'b0;
        chk("start_in_run_pc", 32'(prog_ctr), 32'h1);
        chk("start_in_run_cnt", 32'(Cycle_cnt), 32'h1);
        Stall = 1'b1;
        repeat (65533) step();
        Stall = 1'b0;
        chk("sat_pre_cnt", 32'(Cycle_cnt), 32'hFFFE);
        repeat (5) step();
        chk("sat_cnt", 32'(Cycle_cnt), 32'hFFFF);
        chk("sat_pc", 32'(prog_ctr), 32'h6);
        chk("sat_running", 32'(Running), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
